// File: rtl/io_raster_engine.sv
// Rectangle raster engine: walks a brush or the whole canvas row-major, one
// registered pixel per cycle, clipping anything that falls outside the canvas.
module io_raster_engine #(
    parameter int COORD_W   = 8,
    parameter int COLOR_W   = 3,
    parameter int BRUSH_W   = 10,
    parameter int BRUSH_H   = 14,
    parameter int CANVAS_X0 = 89,
    parameter int CANVAS_Y0 = 33,
    parameter int CANVAS_W  = 140,
    parameter int CANVAS_H  = 196,
    parameter int BG_COLOR  = 0
) (
    input  logic               clock,
    input  logic               count_reset,
    input  logic               start,
    input  logic               mode,
    input  logic               abort,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [COLOR_W-1:0] color_in,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam int SUM_W = COORD_W + 1;
    localparam int MAX_W = (CANVAS_W > BRUSH_W) ? CANVAS_W : BRUSH_W;
    localparam int MAX_H = (CANVAS_H > BRUSH_H) ? CANVAS_H : BRUSH_H;
    localparam int CX_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int CY_W  = (MAX_H > 1) ? $clog2(MAX_H) : 1;

    localparam logic [CX_W-1:0] BRUSH_X_LAST  = CX_W'(BRUSH_W - 1);
    localparam logic [CY_W-1:0] BRUSH_Y_LAST  = CY_W'(BRUSH_H - 1);
    localparam logic [CX_W-1:0] CANVAS_X_LAST = CX_W'(CANVAS_W - 1);
    localparam logic [CY_W-1:0] CANVAS_Y_LAST = CY_W'(CANVAS_H - 1);

    localparam logic [31:0] X_LO = 32'(CANVAS_X0);
    localparam logic [31:0] X_HI = 32'(CANVAS_X0 + CANVAS_W - 1);
    localparam logic [31:0] Y_LO = 32'(CANVAS_Y0);
    localparam logic [31:0] Y_HI = 32'(CANVAS_Y0 + CANVAS_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [1:0]         rst_sync_q;
    logic               mode_q;
    logic [COORD_W-1:0] base_x_q;
    logic [COORD_W-1:0] base_y_q;
    logic [COLOR_W-1:0] color_q;
    logic [CX_W-1:0]    cnt_x_q;
    logic [CY_W-1:0]    cnt_y_q;

    logic               ready_s;
    logic               sel_mode_s;
    logic [COORD_W-1:0] base_x_s;
    logic [COORD_W-1:0] base_y_s;
    logic [COLOR_W-1:0] color_s;
    logic [CX_W-1:0]    last_x_s;
    logic [CY_W-1:0]    last_y_s;
    logic               at_end_s;
    logic [CX_W-1:0]    cnt_x_d;
    logic [CY_W-1:0]    cnt_y_d;
    logic [SUM_W-1:0]   sum_x_d;
    logic [SUM_W-1:0]   sum_y_d;
    logic               plot_d;

    // The window test uses the unwrapped sum so coordinates past 2^COORD_W clip.
    function automatic logic in_window(input logic [SUM_W-1:0] v,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        logic [31:0] w;
        w = 32'(v);
        return (w >= lo) && (w <= hi);
    endfunction

    assign ready_s = rst_sync_q[1];

    // Operation geometry, next counter position and the pixel that position maps to.
    always_comb begin
        sel_mode_s = mode_q;
        base_x_s   = base_x_q;
        base_y_s   = base_y_q;
        color_s    = color_q;
        if (state_q == S_IDLE) begin
            sel_mode_s = mode;
            base_x_s   = x_in;
            base_y_s   = y_in;
            color_s    = color_in;
        end else begin
            sel_mode_s = mode_q;
        end

        last_x_s = BRUSH_X_LAST;
        last_y_s = BRUSH_Y_LAST;
        if (sel_mode_s) begin
            base_x_s = COORD_W'(CANVAS_X0);
            base_y_s = COORD_W'(CANVAS_Y0);
            color_s  = COLOR_W'(BG_COLOR);
            last_x_s = CANVAS_X_LAST;
            last_y_s = CANVAS_Y_LAST;
        end else begin
            last_x_s = BRUSH_X_LAST;
            last_y_s = BRUSH_Y_LAST;
        end

        at_end_s = (cnt_x_q == last_x_s) && (cnt_y_q == last_y_s);

        cnt_x_d = '0;
        cnt_y_d = '0;
        if (state_q != S_RUN) begin
            cnt_x_d = '0;
            cnt_y_d = '0;
        end else if (cnt_x_q == last_x_s) begin
            cnt_x_d = '0;
            cnt_y_d = cnt_y_q + CY_W'(1);
        end else begin
            cnt_x_d = cnt_x_q + CX_W'(1);
            cnt_y_d = cnt_y_q;
        end

        sum_x_d = SUM_W'(base_x_s) + SUM_W'(cnt_x_d);
        sum_y_d = SUM_W'(base_y_s) + SUM_W'(cnt_y_d);
        plot_d  = in_window(sum_x_d, X_LO, X_HI) && in_window(sum_y_d, Y_LO, Y_HI);
    end

    // Reset release is synchronised so a start cannot race the deassertion edge.
    always_ff @(posedge clock or negedge count_reset) begin
        if (!count_reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    // Control FSM; every output is registered here alongside the counters.
    always_ff @(posedge clock or negedge count_reset) begin
        if (!count_reset) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            base_x_q  <= '0;
            base_y_q  <= '0;
            color_q   <= '0;
            cnt_x_q   <= '0;
            cnt_y_q   <= '0;
            x_out     <= '0;
            y_out     <= '0;
            color_out <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && ready_s) begin
                        state_q   <= S_RUN;
                        mode_q    <= mode;
                        base_x_q  <= x_in;
                        base_y_q  <= y_in;
                        color_q   <= color_in;
                        cnt_x_q   <= cnt_x_d;
                        cnt_y_q   <= cnt_y_d;
                        x_out     <= sum_x_d[COORD_W-1:0];
                        y_out     <= sum_y_d[COORD_W-1:0];
                        color_out <= color_s;
                        plot      <= plot_d;
                        busy      <= 1'b1;
                    end else begin
                        plot <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        cnt_x_q <= '0;
                        cnt_y_q <= '0;
                        plot    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else if (at_end_s) begin
                        state_q <= S_DONE;
                        plot    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt_x_q   <= cnt_x_d;
                        cnt_y_q   <= cnt_y_d;
                        x_out     <= sum_x_d[COORD_W-1:0];
                        y_out     <= sum_y_d[COORD_W-1:0];
                        color_out <= color_s;
                        plot      <= plot_d;
                        busy      <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    cnt_x_q <= '0;
                    cnt_y_q <= '0;
                    plot    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    plot    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    io_raster_engine_chk u_chk (
        .clock       (clock),
        .count_reset (count_reset),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

endmodule

// Output-protocol properties of the raster engine.
module io_raster_engine_chk (
    input logic clock,
    input logic count_reset,
    input logic plot,
    input logic busy,
    input logic done
);

    a_done_not_busy: assert property (@(posedge clock) disable iff (!count_reset)
        !(done && busy));

    a_plot_in_run: assert property (@(posedge clock) disable iff (!count_reset)
        plot |-> busy);

    a_done_single: assert property (@(posedge clock) disable iff (!count_reset)
        done |=> !done);

endmodule
